multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multicycle control FSM that sequences the shared CPU datapath (32-bit adder/ALU, regfile,
//   data memory, decoder) one instruction at a time. Latches opcode/funct via ir_we and drives
//   all datapath enables/selects per state. Handshakes with unified memory (instruction + data).
//   Counts retired instructions and traps on illegal opcode or memory timeout.
// PARAMETERS
//   CNT_W        32  width of instr_count
//   MEM_TIMEOUT  16  max cycles waiting on mem_ready before trap (>=1)
// PORTS
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous, active-low reset
//   run          in   1      start/continue execution from IDLE
//   opcode       in   6      instr[31:26], from IR
//   funct        in   6      instr[5:0], from IR
//   zero         in   1      ALU zero flag
//   mem_ready    in   1      memory completes current request this cycle
//   mem_req      out  1      memory access request
//   mem_we       out  1      memory write (valid with mem_req)
//   iord         out  1      0=address from PC, 1=from ALU out reg
//   ir_we        out  1      load instruction register
//   pc_we        out  1      load PC
//   pc_src       out  2      0=PC+4 1=branch target 2=jump target 3=rs
//   alu_a_sel    out  1      0=PC 1=rs
//   alu_b_sel    out  2      0=rt 1=const 4 2=sign-ext imm 3=zero-ext imm
//   alu_cmd      out  3      0 ADD 1 SUB 2 XOR 3 SLT (others unused)
//   reg_we       out  1      regfile write enable
//   reg_dst      out  2      0=rt 1=rd 2=r31
//   dw_sel       out  2      write data: 0=ALU 1=mem 2=PC+4
//   state        out  3      current state encoding (debug)
//   trap         out  1      sticky error flag
//   instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//   States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7. Reset -> IDLE; all outputs 0,
//   instr_count=0, trap=0. Outputs are decoded from state + opcode/funct; no output is
//   asserted outside the listed state.
//   IDLE: run=1 -> FETCH next cycle, else stay.
//   FETCH: mem_req=1, iord=0. Hold until mem_ready; in that cycle ir_we=1, pc_we=1,
//     pc_src=0, alu_a_sel=0, alu_b_sel=1, alu_cmd=ADD; -> DECODE.
//   DECODE: alu_a_sel=0, alu_b_sel=2 (branch target into ALU out reg). Legal opcodes:
//     R(0x00: funct 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x08 JR), LW 0x23, SW 0x2B, ADDI 0x08,
//     XORI 0x0E, BNE 0x05, J 0x02, JAL 0x03. J: pc_we, pc_src=2, retire. JAL: also reg_we,
//     reg_dst=2, dw_sel=2, retire. JR: pc_we, pc_src=3, retire. Illegal -> TRAP. Else -> EXEC.
//   EXEC: alu_a_sel=1. R: alu_b_sel=0, cmd per funct -> WB. ADDI/LW/SW: b=2, ADD.
//     XORI: b=3, XOR -> WB. BNE: b=0, SUB, pc_we=~zero, pc_src=1, retire. LW/SW -> MEM.
//   MEM: mem_req=1, iord=1, mem_we=(SW). Hold until mem_ready. SW retires; LW -> WB.
//   WB: reg_we=1; R: reg_dst=1, dw_sel=0; ADDI/XORI: reg_dst=0, dw_sel=0;
//     LW: reg_dst=0, dw_sel=1. Retire.
//   Retire: instr_count+=1 (wraps at 2^CNT_W), next state FETCH if run=1 else IDLE.
//   Cycles at zero wait: J/JAL/JR 2, BNE 3, R/ADDI/XORI/SW 4, LW 5; +1 per wait cycle.
//   Timeout: counter clears on entering FETCH/MEM; if mem_ready still 0 after MEM_TIMEOUT
//     consecutive cycles -> TRAP. mem_ready outside FETCH/MEM ignored.
//   TRAP: all control outputs 0, trap=1, held until reset_n. run ignored.
//   run dropping mid-instruction: current instruction completes, then IDLE.
//   reset_n low at any time: immediate IDLE, outputs 0, mid-flight write aborted.
// TESTING
//   1 reset, run=1, mem_ready=1, R ADD -> states 1,2,3,5,1; reg_we/reg_dst=1 in WB; count=1.
//   2 LW with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, 8 total, dw_sel=1.
//   3 BNE zero=0 -> pc_we=1 pc_src=1 in EXEC; zero=1 -> pc_we=0; both retire in 3.
//   4 JAL -> reg_we, reg_dst=2, dw_sel=2, pc_src=2 in DECODE; next state FETCH.
//   5 opcode 0x3F -> TRAP after DECODE, trap=1 sticky; mem_ready stuck 0 in FETCH -> TRAP
//     after MEM_TIMEOUT=16 cycles.
//   6 reset_n low during MEM of SW -> outputs 0 same cycle; CNT_W=4, 16 retires -> count 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: 2-5 cycles per instruction at zero wait, outputs decoded from registered state.
// Stalls in FETCH/MEM while mem_ready is low; traps after MEM_TIMEOUT idle cycles and holds until reset.
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [2:0]       alu_cmd,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       dw_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2A, F_JR = 6'h08;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              trap_q, trap_d;
    logic              retire;

    logic is_r, r_add, r_sub, r_slt, r_jr, is_lw, is_sw, is_addi, is_xori, is_bne, is_j, is_jal, legal;

    assign is_r    = (opcode == OP_R);
    assign r_add   = is_r && (funct == F_ADD);
    assign r_sub   = is_r && (funct == F_SUB);
    assign r_slt   = is_r && (funct == F_SLT);
    assign r_jr    = is_r && (funct == F_JR);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_addi = (opcode == OP_ADDI);
    assign is_xori = (opcode == OP_XORI);
    assign is_bne  = (opcode == OP_BNE);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);
    assign legal   = r_add | r_sub | r_slt | r_jr | is_lw | is_sw | is_addi |
                     is_xori | is_bne | is_j | is_jal;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 2'd0;
        alu_cmd   = 3'd0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        dw_sel    = 2'd0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_b_sel = 2'd1;
                    state_d   = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively here for a following BNE.
                alu_b_sel = 2'd2;
                if (is_j || is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    retire = 1'b1;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        dw_sel  = 2'd2;
                    end
                end else if (r_jr) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd3;
                    retire = 1'b1;
                end else if (!legal) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a_sel = 1'b1;
                state_d   = S_WB;
                if (is_r) begin
                    alu_cmd = r_sub ? 3'd1 : (r_slt ? 3'd3 : 3'd0);
                end else if (is_xori) begin
                    alu_b_sel = 2'd3;
                    alu_cmd   = 3'd2;
                end else if (is_bne) begin
                    alu_cmd = 3'd1;
                    pc_we   = ~zero;
                    pc_src  = 2'd1;
                    retire  = 1'b1;
                end else begin
                    alu_b_sel = 2'd2;
                    if (is_lw || is_sw) begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) retire = 1'b1;
                    else       state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_r ? 2'd1 : 2'd0;
                dw_sel  = is_lw ? 2'd1 : 2'd0;
                retire  = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
            wait_d  = '0;
        end
        trap_d = trap_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
        end
    end

    assign state       = state_q;
    assign trap        = trap_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors queued per instruction.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset_n, run, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord, ir_we, pc_we, alu_a_sel, reg_we, trap;
    logic [1:0] pc_src, alu_b_sel, reg_dst, dw_sel;
    logic [2:0] alu_cmd, state;
    logic [3:0] instr_count;

    int checks = 0;
    int fails  = 0;
    logic [3:0] exp_count;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       alu_a;
        logic [1:0] alu_b;
        logic [2:0] cmd;
        logic       reg_we;
        logic [1:0] reg_dst, dw_sel;
    } ctl_t;
    typedef struct { ctl_t c; logic rdy; } exp_t;
    exp_t sb[$];

    multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_cmd(alu_cmd),
        .reg_we(reg_we), .reg_dst(reg_dst), .dw_sel(dw_sel), .state(state),
        .trap(trap), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t observed();
        ctl_t o;
        o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord;
        o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.alu_a = alu_a_sel;
        o.alu_b = alu_b_sel; o.cmd = alu_cmd; o.reg_we = reg_we;
        o.reg_dst = reg_dst; o.dw_sel = dw_sel;
        return o;
    endfunction

    function automatic void push(input ctl_t c, input logic rdy);
        exp_t e;
        e.c = c; e.rdy = rdy;
        sb.push_back(e);
    endfunction

    // Expected control vectors for one instruction, straight from the per-state output table.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                  input int fw, input int mw);
        ctl_t c;
        bit rtype, jr, jclass, memop;
        rtype  = (op == 6'h00);
        jr     = rtype && (fn == 6'h08);
        jclass = (op == 6'h02) || (op == 6'h03) || jr;
        memop  = (op == 6'h23) || (op == 6'h2B);
        for (int i = 0; i < fw; i++) begin
            c = '0; c.st = 3'd1; c.mem_req = 1'b1; push(c, 1'b0);
        end
        c = '0; c.st = 3'd1; c.mem_req = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1; c.alu_b = 2'd1;
        push(c, 1'b1);
        c = '0; c.st = 3'd2; c.alu_b = 2'd2;
        if (op == 6'h02 || op == 6'h03) begin c.pc_we = 1'b1; c.pc_src = 2'd2; end
        if (op == 6'h03) begin c.reg_we = 1'b1; c.reg_dst = 2'd2; c.dw_sel = 2'd2; end
        if (jr) begin c.pc_we = 1'b1; c.pc_src = 2'd3; end
        push(c, 1'b0);
        if (jclass || op == 6'h3F) return;
        c = '0; c.st = 3'd3; c.alu_a = 1'b1;
        if (rtype)            c.cmd = (fn == 6'h22) ? 3'd1 : ((fn == 6'h2A) ? 3'd3 : 3'd0);
        else if (op == 6'h0E) begin c.alu_b = 2'd3; c.cmd = 3'd2; end
        else if (op == 6'h05) begin c.cmd = 3'd1; c.pc_we = ~z; c.pc_src = 2'd1; end
        else                  c.alu_b = 2'd2;
        push(c, 1'b0);
        if (op == 6'h05) return;
        if (memop) begin
            c = '0; c.st = 3'd4; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (op == 6'h2B);
            for (int i = 0; i < mw; i++) push(c, 1'b0);
            push(c, 1'b1);
            if (op == 6'h2B) return;
        end
        c = '0; c.st = 3'd5; c.reg_we = 1'b1;
        c.reg_dst = rtype ? 2'd1 : 2'd0;
        c.dw_sel  = (op == 6'h23) ? 2'd1 : 2'd0;
        push(c, 1'b0);
    endfunction

    // Runs one instruction starting from FETCH; exp_cyc is the cycle count the instruction should take.
    task automatic exec_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int fw, input int mw, input bit drop_run,
                              input bit illegal, input int exp_cyc);
        exp_t e;
        ctl_t o;
        logic [3:0] start_cnt;
        int cyc = 0;
        bit done = 0;
        opcode = op; funct = fn; zero = z;
        build(op, fn, z, fw, mw);
        start_cnt = instr_count;
        while (!done && cyc < 64) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin
                mem_ready = 1'b0;
                fails++;
                $display("FAIL %s extra_cycle: state=%0d, no further cycle expected", name, state);
            end else begin
                e = sb.pop_front();
                mem_ready = e.rdy;
                #1;
                o = observed();
                if (o !== e.c) begin
                    fails++;
                    $display("FAIL %s ctl_cycle%0d: got %h expected %h", name, cyc, o, e.c);
                end
            end
            if (drop_run) run = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (instr_count !== start_cnt || state == 3'd7) done = 1;
        end
        checks++;
        if (cyc !== exp_cyc) begin
            fails++;
            $display("FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s leftover: %0d expected cycles not seen", name, sb.size());
        end
        sb.delete();
        if (illegal) begin
            checks++;
            if (state !== 3'd7 || trap !== 1'b1) begin
                fails++;
                $display("FAIL %s trap_entry: state=%0d trap=%b expected 7/1", name, state, trap);
            end
        end else begin
            exp_count = exp_count + 4'd1;
            checks++;
            if (instr_count !== exp_count) begin
                fails++;
                $display("FAIL %s count: got %0d expected %0d", name, instr_count, exp_count);
            end
            checks++;
            if (state !== (run ? 3'd1 : 3'd0)) begin
                fails++;
                $display("FAIL %s next_state: got %0d expected %0d", name, state, run ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'h00; funct = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== ctl_t'(0) || trap !== 1'b0 || instr_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: ctl=%h trap=%b count=%0d expected all 0", observed(), trap, instr_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_count = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL idle_hold: state=%0d expected 0", state);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL start_fetch: state=%0d expected 1", state);
        end
    endtask

    task automatic test_r_add();
        start_run();
        exec_instr("r_add", 6'h00, 6'h20, 1'b0, 0, 0, 0, 0, 4);
    endtask

    task automatic test_alu_ops();
        exec_instr("r_sub",  6'h00, 6'h22, 1'b0, 0, 0, 0, 0, 4);
        exec_instr("r_slt",  6'h00, 6'h2A, 1'b0, 1, 0, 0, 0, 5);
        exec_instr("addi",   6'h08, 6'h3F, 1'b0, 0, 0, 0, 0, 4);
        exec_instr("xori",   6'h0E, 6'h00, 1'b1, 0, 0, 0, 0, 4);
        exec_instr("sw",     6'h2B, 6'h00, 1'b0, 0, 0, 0, 0, 4);
        exec_instr("jr",     6'h00, 6'h08, 1'b0, 0, 0, 0, 0, 2);
    endtask

    task automatic test_lw_wait();
        exec_instr("lw_mwait3", 6'h23, 6'h00, 1'b0, 0, 3, 0, 0, 8);
        exec_instr("lw_fwait2", 6'h23, 6'h00, 1'b0, 2, 0, 0, 0, 7);
    endtask

    task automatic test_bne();
        exec_instr("bne_taken",  6'h05, 6'h00, 1'b0, 0, 0, 0, 0, 3);
        exec_instr("bne_not",    6'h05, 6'h00, 1'b1, 0, 0, 0, 0, 3);
    endtask

    task automatic test_jumps();
        exec_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0, 0, 0, 2);
        exec_instr("j",   6'h02, 6'h00, 1'b0, 0, 0, 0, 0, 2);
    endtask

    task automatic test_run_drop();
        exec_instr("run_drop", 6'h00, 6'h20, 1'b0, 0, 0, 1, 0, 4);
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL run_drop_idle: state=%0d expected 0", state);
        end
        start_run();
    endtask

    task automatic test_sw_reset();
        opcode = 6'h2B; funct = 6'h00;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd4 || mem_we !== 1'b1) begin
            fails++;
            $display("FAIL sw_mem_reached: state=%0d mem_we=%b expected 4/1", state, mem_we);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (observed() !== ctl_t'(0) || instr_count !== 4'd0 || trap !== 1'b0) begin
            fails++;
            $display("FAIL sw_async_reset: ctl=%h count=%0d expected all 0", observed(), instr_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run = 1'b0;
        exp_count = 4'd0;
    endtask

    task automatic test_illegal_trap();
        start_run();
        exec_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            run = i[0];
            #1;
            checks++;
            if (state !== 3'd7 || trap !== 1'b1 || (observed() & ~ctl_t'(21'h1C0000)) !== ctl_t'(0)) begin
                fails++;
                $display("FAIL trap_sticky: state=%0d trap=%b ctl=%h expected 7/1/quiet", state, trap, observed());
            end
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        test_reset();
        start_run();
        while (state == 3'd1 && cyc < 40) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            checks++;
            if (mem_req !== 1'b1) begin
                fails++;
                $display("FAIL timeout_req: mem_req=%b expected 1", mem_req);
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 16 || state !== 3'd7 || trap !== 1'b1) begin
            fails++;
            $display("FAIL fetch_timeout: cycles=%0d state=%0d trap=%b expected 16/7/1", cyc, state, trap);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        start_run();
        for (int i = 0; i < 16; i++) exec_instr("b2b_j", 6'h02, 6'h00, 1'b0, 0, 0, 0, 0, 2);
        checks++;
        if (instr_count !== 4'd0) begin
            fails++;
            $display("FAIL count_wrap: got %0d expected 0", instr_count);
        end
    endtask

    initial begin
        exp_count = 4'd0;
        test_reset();
        test_r_add();
        test_alu_ops();
        test_lw_wait();
        test_bne();
        test_jumps();
        test_run_drop();
        test_sw_reset();
        test_illegal_trap();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
